rr_encoder4: RTL and testbench

- Sequential counterpart of the team's one-hot decoder: collects one-hot/multi-hot request pulses and emits them as binary indices, one at a time, over a valid/ready handshake.
- Round-robin priority prevents starvation.
- Sits between interrupt/event sources (N request lines) and a consumer that takes one binary-coded event per transfer.

---
 rtl/rr_encoder4_if.sv | 23 ++
 rtl/rr_encoder4.sv | 108 ++++++++++
 tb/tb_rr_encoder4.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_encoder4_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_encoder4_if
// Description : Request / grant handshake bundle for the round-robin encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_encoder4_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic [N-1:0] req;
    logic         enable;
    logic [W-1:0] out;
    logic         valid;
    logic         ready;
    logic [N-1:0] pending;
    logic         dup;

    // master: request sources plus consumer; slave: the encoder itself
    modport master (output req, enable, ready, input out, valid, pending, dup);
    modport slave  (input req, enable, ready, output out, valid, pending, dup);
endinterface
`default_nettype wire

// File: rtl/rr_encoder4.sv
`default_nettype none
// ============================================================================
// Module      : rr_encoder4
// Description : Collects multi-hot request pulses and delivers them one at a
//               time as binary indices with round-robin priority.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_encoder4 #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  wire logic     clock,
    input  wire logic     reset,
    rr_encoder4_if.slave  bus
);
    // N must equal 2**W so that W-bit index arithmetic wraps modulo N.
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] out_q, out_d;
    logic         valid_q, valid_d;
    logic         dup_q, dup_d;

    logic [N-1:0] w_new;
    logic [N-1:0] w_clr;
    logic [W-1:0] w_sel;
    logic         w_found;

    // First pending line at or after ptr, wrapping modulo N.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && pending_q[ptr_q + W'(k)]) begin
                w_sel   = ptr_q + W'(k);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_new = bus.req & {N{bus.enable}};
        w_clr = '0;
        if (state_q == S_HOLD && bus.ready) begin
            w_clr[out_q] = 1'b1;
        end

        // A set arriving alongside a clear of the same line keeps it pending.
        pending_d = (pending_q & ~w_clr) | w_new;
        dup_d     = |(w_new & pending_q & ~w_clr);

        state_d = state_q;
        ptr_d   = ptr_q;
        out_d   = out_q;
        valid_d = valid_q;

        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (w_found) begin
                    out_d   = w_sel;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ready) begin
                    ptr_d   = out_q + W'(1);
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            dup_q     <= dup_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.valid   = valid_q;
    assign bus.pending = pending_q;
    assign bus.dup     = dup_q;
endmodule
`default_nettype wire

// File: tb/tb_rr_encoder4.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_encoder4
// Description : Self-checking bench for rr_encoder4 against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_encoder4;
    localparam int N = 4;
    localparam int W = 2;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    rr_encoder4_if #(.N(N), .W(W)) bus ();

    rr_encoder4 #(.N(N), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model: pending set, pointer, and the currently offered grant.
    bit  m_pend [N];
    int  m_ptr;
    int  m_out;
    bit  m_valid;
    bit  m_dup;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pend_val();
        int v = 0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    always @(posedge clock) begin
        bit nw [N];
        bit nxt [N];
        int clr_idx;
        bit any;
        if (reset) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_ptr = 0; m_out = 0; m_valid = 1'b0; m_dup = 1'b0;
        end else begin
            clr_idx = (m_valid && bus.ready) ? m_out : -1;
            m_dup = 1'b0;
            for (int i = 0; i < N; i++) begin
                nw[i]  = bus.req[i] && bus.enable;
                if (nw[i] && m_pend[i] && i != clr_idx) m_dup = 1'b1;
                nxt[i] = (m_pend[i] && i != clr_idx) || nw[i];
            end
            if (m_valid) begin
                if (bus.ready) begin
                    m_ptr   = (m_out + 1) % N;
                    m_valid = 1'b0;
                end
            end else begin
                any = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!any && m_pend[(m_ptr + k) % N]) begin
                        any     = 1'b1;
                        m_out   = (m_ptr + k) % N;
                        m_valid = 1'b1;
                    end
                end
            end
            for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
        end
        #1;
        chk("model_out",     int'(bus.out),     m_out);
        chk("model_valid",   int'(bus.valid),   int'(m_valid));
        chk("model_pending", int'(bus.pending), pend_val());
        chk("model_dup",     int'(bus.dup),     int'(m_dup));
    end

    task automatic step(input logic [3:0] r, input logic e, input logic rd);
        bus.req    = r;
        bus.enable = e;
        bus.ready  = rd;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'b0000, 1'b1, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.req = '0; bus.enable = 1'b1; bus.ready = 1'b1;

        // Single request, then pointer position proven by the next grant order
        do_reset();
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_out", int'(bus.out), 0);
        chk("rst_pending", int'(bus.pending), 0);
        step(4'b0100, 1, 1);
        chk("t1_pend_e0", int'(bus.pending), 4'b0100);
        chk("t1_valid_e0", int'(bus.valid), 0);
        step(4'b0000, 1, 1);
        chk("t1_valid_e1", int'(bus.valid), 1);
        chk("t1_out_e1", int'(bus.out), 2);
        step(4'b0000, 1, 1);
        chk("t1_valid_acc", int'(bus.valid), 0);
        chk("t1_pend_acc", int'(bus.pending), 0);
        chk("t1_out_kept", int'(bus.out), 2);
        step(4'b0101, 1, 1);
        step(4'b0000, 1, 1);
        chk("t1_ptr3_grant", int'(bus.out), 0);
        step(4'b0000, 1, 1);
        step(4'b0000, 1, 1);
        chk("t1_ptr1_grant", int'(bus.out), 2);

        // Multi-hot burst drained in order 0,1,3 then pointer wraps to 0
        do_reset();
        step(4'b1011, 1, 1);
        step(4'b0000, 1, 1); chk("t2_g0", int'(bus.out), 0);
        step(4'b0000, 1, 1); chk("t2_p0", int'(bus.pending), 4'b1010);
        step(4'b0000, 1, 1); chk("t2_g1", int'(bus.out), 1);
        step(4'b0000, 1, 1);
        step(4'b0000, 1, 1); chk("t2_g3", int'(bus.out), 3);
        step(4'b0000, 1, 1); chk("t2_pend_end", int'(bus.pending), 0);
        step(4'b1111, 1, 1);
        step(4'b0000, 1, 1); chk("t2_wrap_grant", int'(bus.out), 0);

        // Starvation: ptr=1, lines 0 and 2 hammered -> 2,0,2,0
        do_reset();
        step(4'b0001, 1, 1);
        step(4'b0000, 1, 1);
        step(4'b0000, 1, 1);
        step(4'b0101, 1, 1);
        for (int k = 0; k < 4; k++) begin
            step(4'b0101, 1, 1);
            chk("t3_valid", int'(bus.valid), 1);
            chk("t3_out", int'(bus.out), (k % 2 == 0) ? 2 : 0);
            step(4'b0101, 1, 1);
        end

        // Backpressure holds the grant stable
        do_reset();
        step(4'b0010, 1, 0);
        step(4'b0000, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(4'b1000, 1, 0);
            chk("t4_out_hold", int'(bus.out), 1);
            chk("t4_valid_hold", int'(bus.valid), 1);
            chk("t4_pend_hold", int'(bus.pending), 4'b1010);
        end
        step(4'b0000, 1, 1); chk("t4_acc_valid", int'(bus.valid), 0);
        step(4'b0000, 1, 1); chk("t4_next_out", int'(bus.out), 3);

        // Duplicate request and set-wins-over-clear
        do_reset();
        step(4'b0100, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b0100, 1, 0);
        chk("t5_dup", int'(bus.dup), 1);
        chk("t5_pend", int'(bus.pending), 4'b0100);
        step(4'b0000, 1, 0); chk("t5_dup_clear", int'(bus.dup), 0);
        step(4'b0100, 1, 1);
        chk("t5_dup_setclr", int'(bus.dup), 0);
        chk("t5_pend_setclr", int'(bus.pending), 4'b0100);
        step(4'b0000, 1, 1);
        chk("t5_regrant_v", int'(bus.valid), 1);
        chk("t5_regrant", int'(bus.out), 2);

        // enable gating and reset during a held grant
        do_reset();
        step(4'b1111, 0, 1);
        chk("t6_en_pend", int'(bus.pending), 0);
        chk("t6_en_valid", int'(bus.valid), 0);
        step(4'b0010, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b1111, 0, 0);
        chk("t6_hold_valid", int'(bus.valid), 1);
        chk("t6_hold_out", int'(bus.out), 1);
        chk("t6_hold_pend", int'(bus.pending), 4'b0010);
        do_reset();
        chk("t6_rst_valid", int'(bus.valid), 0);
        chk("t6_rst_out", int'(bus.out), 0);
        chk("t6_rst_pend", int'(bus.pending), 0);
        chk("t6_rst_dup", int'(bus.dup), 0);

        // Randomized traffic, checked every cycle by the model
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
        end
        reset = 1'b0;
        step(4'b0000, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
